// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
    StChk,
    StDone,
    StErr
  } state_e;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned LANE_W    = 8;

  // Byte address of word `idx`, wrapping at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler with a running XOR checksum of all shifted bytes.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [LANE_W-1:0] data,
  output logic [31:0]       word,
  output logic [31:0]       word_next,
  output logic [7:0]        checksum,
  output logic              word_complete
);

  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic [7:0]  checksum_q;

  // Word including the byte being shifted this cycle, so the writer can latch it on the 4th byte.
  always_comb begin
    word_next = word_q;
    word_next[{lane_q, 3'b000} +: LANE_W] = data;
  end

  assign word_complete = shift && (lane_q == 2'd3);
  assign word          = word_q;
  assign checksum      = checksum_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_q     <= 2'd0;
      word_q     <= 32'd0;
      checksum_q <= 8'd0;
    end else if (shift) begin
      lane_q     <= lane_q + 2'd1;
      word_q     <= word_next;
      checksum_q <= checksum_q ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// holds the core in reset until a verified program is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  state_e      state;
  logic [15:0] len_q;
  logic [15:0] len_next;
  logic        xfer;
  logic        start_ok;
  logic        shift;
  logic [31:0] word;
  logic [31:0] word_next;
  logic [7:0]  checksum;
  logic        word_complete;

  assign xfer     = byte_valid && byte_ready;
  assign start_ok = start && (state == StIdle || state == StDone || state == StErr);
  assign shift    = xfer && (state == StData);
  assign len_next = {byte_data, len_q[7:0]};

  imem_loader_word_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_ok),
    .shift         (shift),
    .data          (byte_data),
    .word          (word),
    .word_next     (word_next),
    .checksum      (checksum),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      len_q        <= 16'd0;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= 32'd0;
      imem_wdata   <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        StIdle, StDone, StErr: begin
          if (start_ok) begin
            state        <= StLen0;
            byte_ready   <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
          end
        end
        StLen0: begin
          if (xfer) begin
            len_q[7:0] <= byte_data;
            state      <= StLen1;
          end
        end
        StLen1: begin
          if (xfer) begin
            len_q[15:8] <= byte_data;
            if (32'(len_next) > DEPTH_WORDS) begin
              state      <= StErr;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= StChk;
            end else begin
              state <= StData;
            end
          end
        end
        StData: begin
          // The stream stalls for the write cycle, capping throughput at one word per 5 cycles.
          if (word_complete) begin
            state      <= StWrite;
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= word_addr(BASE_ADDR, words_loaded);
            imem_wdata <= word_next;
          end
        end
        StWrite: begin
          words_loaded <= words_loaded + 16'd1;
          byte_ready   <= 1'b1;
          state        <= (words_loaded + 16'd1 == len_q) ? StChk : StData;
        end
        StChk: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_data == checksum) begin
              state    <= StDone;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= StErr;
              error <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: two loaders (base 0 and base 0x100) share one byte stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;

  logic        ready0, we0, hold0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic [15:0] wl0;
  logic        ready1, we1, hold1, done1, err1;
  logic [31:0] addr1, wdata1;
  logic [15:0] wl1;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .cpu_hold(hold0), .done(done0), .error(err0), .words_loaded(wl0)
  );

  imem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .cpu_hold(hold1), .done(done1), .error(err1), .words_loaded(wl1)
  );

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Write monitor; the stream must be stalled whenever a write is in progress.
  always @(negedge clk) begin
    if (we0) begin
      wa0.push_back(addr0);
      wd0.push_back(wdata0);
      check("ready_low_in_write0", {31'd0, ready0}, 32'd0);
    end
    if (we1) begin
      wa1.push_back(addr1);
      wd1.push_back(wdata1);
      check("ready_low_in_write1", {31'd0, ready1}, 32'd0);
    end
  end

  typedef struct packed {
    logic [95:0] bytes;   // first stream byte in the top octet
    logic [7:0]  nbytes;
    logic        gaps;
    logic [1:0]  nwr;
    logic [31:0] wd_a;
    logic [31:0] wd_b;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_wl;
  } vec_t;

  vec_t vecs[6];

  task automatic send_byte(input logic [7:0] b, input logic gap);
    logic r;
    bit   ok = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 50; t++) begin
      r = ready0;
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) begin
      nvec++;
      nfail++;
      $display("FAIL byte_timeout: got no transfer want transfer of %h", b);
    end
  endtask

  task automatic pulse_start();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_final(input string tag, input vec_t v);
    check({tag, "_nwr0"}, wa0.size(), {30'd0, v.nwr});
    check({tag, "_nwr1"}, wa1.size(), {30'd0, v.nwr});
    for (int i = 0; i < int'(v.nwr) && i < wa0.size() && i < wa1.size(); i++) begin
      check({tag, "_addr0"}, wa0[i], 32'(4 * i));
      check({tag, "_addr1"}, wa1[i], 32'h100 + 32'(4 * i));
      check({tag, "_wdata0"}, wd0[i], (i == 0) ? v.wd_a : v.wd_b);
      check({tag, "_wdata1"}, wd1[i], (i == 0) ? v.wd_a : v.wd_b);
    end
    check({tag, "_done"}, {31'd0, done0}, {31'd0, v.exp_done});
    check({tag, "_error"}, {31'd0, err0}, {31'd0, v.exp_err});
    check({tag, "_hold"}, {31'd0, hold0}, {31'd0, ~v.exp_done});
    check({tag, "_wl"}, {16'd0, wl0}, {16'd0, v.exp_wl});
    check({tag, "_done1"}, {31'd0, done1}, {31'd0, v.exp_done});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, ready0}, 32'd0);
    check({tag, "_we"}, {31'd0, we0}, 32'd0);
    check({tag, "_addr"}, addr0, 32'd0);
    check({tag, "_wdata"}, wdata0, 32'd0);
    check({tag, "_hold"}, {31'd0, hold0}, 32'd1);
    check({tag, "_done"}, {31'd0, done0}, 32'd0);
    check({tag, "_error"}, {31'd0, err0}, 32'd0);
    check({tag, "_wl"}, {16'd0, wl0}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    pulse_start();
    check("start_done_clear", {31'd0, done0}, 32'd0);
    check("start_error_clear", {31'd0, err0}, 32'd0);
    check("start_hold", {31'd0, hold0}, 32'd1);
    check("start_wl_clear", {16'd0, wl0}, 32'd0);
    check("start_ready", {31'd0, ready0}, 32'd1);
    for (int i = 0; i < int'(v.nbytes); i++) send_byte(v.bytes[95 - 8 * i -: 8], v.gaps);
    @(negedge clk);
  endtask

  initial begin
    //                   stream bytes                          n   gap nwr wdata a        wdata b       dn er wl
    vecs[0] = '{96'h01_00_13_01_50_00_42_00_00_00_00_00, 8'd7,  1'b0, 2'd1, 32'h00500113, 32'h0, 1'b1, 1'b0, 16'd1};
    vecs[1] = '{96'h02_00_13_01_50_00_93_01_A0_00_70_00, 8'd11, 1'b1, 2'd2, 32'h00500113, 32'h00A00193, 1'b1, 1'b0, 16'd2};
    vecs[2] = '{96'h01_00_13_01_50_00_43_00_00_00_00_00, 8'd7,  1'b0, 2'd1, 32'h00500113, 32'h0, 1'b0, 1'b1, 16'd1};
    vecs[3] = '{96'h41_00_00_00_00_00_00_00_00_00_00_00, 8'd2,  1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0};
    vecs[4] = '{96'h00_00_00_00_00_00_00_00_00_00_00_00, 8'd3,  1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 16'd0};
    vecs[5] = '{96'h00_00_01_00_00_00_00_00_00_00_00_00, 8'd3,  1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k]);
      check_final($sformatf("vec%0d", k), vecs[k]);
    end

    // Reset in the middle of DATA returns everything to reset values on the next edge.
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0); send_byte(8'h01, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    check("midreset_nwr", wa0.size(), 32'd0);
    run_vec(vecs[0]);
    check_final("after_reset", vecs[0]);

    // start pulsed during DATA must be ignored.
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0); send_byte(8'h01, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h42, 1'b0);
    @(negedge clk);
    check_final("start_in_data", vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The single-cycle core only reads instructions; this block fills the memory with instructions.
- Receives a program as a byte stream using a valid/ready handshake. Packs the bytes into little-endian 32-bit instruction words and writes them word-by-word into instruction memory.
- Holds the core in reset until a complete, checksum-verified program has been written.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word. Must be word aligned.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte this cycle
- imem_we  output  1  instruction memory write enable
- imem_addr  output  32  byte address of the word write
- imem_wdata  output  32  instruction word
- cpu_hold  output  1  reset/hold for the core
- done  output  1  load completed successfully
- error  output  1  load failed (length or checksum)
- words_loaded  output  16  count of words written in the current or last load

Behaviour:
- Transfer rule: a byte transfers on a rising clk edge when byte_valid & byte_ready are both high. byte_data is sampled only on a transfer.
- Stream format:
  - len_lo, len_hi: N, 16-bit little-endian.
  - 4*N data bytes: each word is LSB first.
  - 1 checksum byte: XOR of all data bytes only. With N=0 the expected checksum is 8'h00.
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, state=IDLE.
- States:
  - IDLE: byte_ready=0. start -> LEN0.
  - LEN0: byte_ready=1. Transfer -> capture len[7:0] -> LEN1.
  - LEN1: byte_ready=1. Transfer -> capture len[15:8]. Then:
    - If N>DEPTH_WORDS -> ERR.
    - Else if N==0 -> CHK.
    - Else -> DATA.
  - DATA: byte_ready=1. Shift the byte into the assembly register at lane = byte index mod 4 and XOR it into the checksum. On the 4th byte of a word -> WRITE.
  - WRITE: byte_ready=0. imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+4*index, imem_wdata=assembled word. words_loaded increments at the end of this cycle. If this was word N -> CHK, else -> DATA.
  - CHK: byte_ready=1. Transfer -> DONE if the byte equals the running XOR, else ERR.
  - DONE: done=1, cpu_hold=0.
  - ERR: error=1, cpu_hold=1.
- cpu_hold is 1 in every state except DONE.
- start clears done, error, words_loaded, the checksum and the byte lane on the cycle it is honoured. It drops done before re-entering LEN0, so the core is re-held.
- start in LEN0, LEN1, DATA, WRITE or CHK is ignored.
- Outputs imem_addr and imem_wdata hold their last values when imem_we=0.
- Throughput: at most one write per 5 cycles, because WRITE stalls the stream for one cycle. No write ever occurs outside WRITE.
- Address arithmetic: the word index is 16 bits, imem_addr = BASE_ADDR + {index,2'b00} truncated to 32 bits. The index never exceeds DEPTH_WORDS-1 because of the length check.
- Reset mid-load takes priority over all other inputs and returns every register to its reset value on the next edge. A partially written memory is not erased, but cpu_hold stays 1.
- byte_valid high while byte_ready=0 is not consumed; the source must hold the byte.

Decomposition:
- Shared package (imem_loader_pkg):
  - State enumeration: IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR, 3-bit encoding.
  - HDR_BYTES=2.
  - Byte-lane width constant.
- One natural sub-module: word_packer. Holds the 2-bit lane counter, the 32-bit little-endian assembly register, the running XOR checksum and the word_complete strobe. The top holds the FSM, the length and index counters, and the imem/handshake outputs.

Test Plan:
- Single word: start, then 01 00 13 01 50 00 42.
  - Expected: one imem_we pulse with addr=0x0, wdata=0x00500113.
  - Then done=1, cpu_hold=0, words_loaded=1.
- Two words with BASE_ADDR=0x100, random byte_valid gaps:
  - Write 1: addr=0x100.
  - Write 2: addr=0x104.
  - byte_ready=0 during each WRITE cycle.
  - Stalled bytes are not lost; done=1.
- Bad checksum: same as the single-word case but with checksum 0x43.
  - Expected: the write still occurs, then error=1, done=0, cpu_hold=1.
- Oversize length with DEPTH_WORDS=64: length bytes 41 00 (N=65).
  - Expected: ERR immediately after len_hi, with zero imem_we pulses.
- Zero length: 00 00 00.
  - Expected: done=1, words_loaded=0, no writes.
  - With 00 00 01 instead: error=1.
- Reset mid-DATA: assert reset after 2 data bytes.
  - Expected: all outputs return to reset values next cycle.
  - A fresh start with a valid stream then completes normally.
